// File: rtl/frame_uart_pkg.sv
// Constants and state encoding shared by the UART-link frame sender and receiver.
package frame_uart_pkg;

  localparam logic [7:0] START_BYTE  = 8'h00;
  localparam logic [7:0] END_BYTE    = 8'h0F;
  localparam int         FRAME_WIDTH = 160;
  localparam logic [3:0] SEQ_FIRST   = 4'd1;
  localparam logic [3:0] SEQ_LAST    = 4'd15;

  typedef enum logic [1:0] {
    IDLE,
    SEND_START,
    SEND_DATA,
    SEND_END
  } frame_state_e;

  // Sequence numbers cycle 1..15 so a data byte can never alias a start/end byte.
  function automatic logic [3:0] next_seq(input logic [3:0] seq);
    return (seq == SEQ_LAST) ? SEQ_FIRST : seq + 4'd1;
  endfunction

endpackage

// File: rtl/frame_hold_buf.sv
// One-deep holding register with a valid flag; parks a frame accepted mid-transmission.
module frame_hold_buf #(
  parameter int WIDTH = 160
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic [WIDTH-1:0] data
);

  logic             full_q, full_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    full_d = (full_q & ~pop) | push;
    data_d = push ? push_data : data_q;
  end

  always_ff @(posedge clk) begin
    if (reset) full_q <= 1'b0;
    else       full_q <= full_d;
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign full = full_q;
  assign data = data_q;

endmodule

// File: rtl/frame_send.sv
// Serializes a frame into 00, {seq,nibble} x NIBBLES, 0F for the UART transmitter.
// Define FRAME_SEND_QUEUE_EN to add a one-deep frame holding register.
module frame_send
  import frame_uart_pkg::*;
#(
  parameter int NIBBLES = FRAME_WIDTH / 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 frame_valid,
  output logic                 frame_ready,
  input  logic [4*NIBBLES-1:0] frame_data,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 done
);

  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = $clog2(NIBBLES);

  frame_state_e     state_q, state_d;
  logic [W-1:0]     shreg_q, shreg_d;
  logic [3:0]       seq_q, seq_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             done_q, done_d;
  logic [7:0]       tx_data_c;

  logic             accept;
  logic             load_now;
  logic [W-1:0]     load_data;

  assign accept = frame_valid & frame_ready;

`ifdef FRAME_SEND_QUEUE_EN
  logic         hold_full, hold_push, hold_pop, direct_load, end_xfer;
  logic [W-1:0] hold_data;

  assign end_xfer    = (state_q == SEND_END) & tx_ready;
  // A new frame bypasses the holding register when the engine is free to take it now.
  assign direct_load = accept & ((state_q == IDLE) | (end_xfer & ~hold_full));
  assign hold_push   = accept & ~direct_load;
  assign hold_pop    = end_xfer & hold_full;
  assign load_now    = direct_load | hold_pop;
  assign load_data   = hold_pop ? hold_data : frame_data;
  assign frame_ready = ~reset & ~hold_full;

  frame_hold_buf #(
    .WIDTH(W)
  ) u_hold (
    .clk      (clk),
    .reset    (reset),
    .push     (hold_push),
    .push_data(frame_data),
    .pop      (hold_pop),
    .full     (hold_full),
    .data     (hold_data)
  );
`else
  assign load_now    = accept;
  assign load_data   = frame_data;
  assign frame_ready = ~reset & (state_q == IDLE);
`endif

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    seq_d     = seq_q;
    idx_d     = idx_q;
    done_d    = 1'b0;
    tx_data_c = START_BYTE;

    case (state_q)
      IDLE: ;
      SEND_START: begin
        if (tx_ready) state_d = SEND_DATA;
      end
      SEND_DATA: begin
        tx_data_c = {seq_q, shreg_q[W-1 -: 4]};
        if (tx_ready) begin
          shreg_d = shreg_q << 4;
          seq_d   = next_seq(seq_q);
          idx_d   = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(NIBBLES - 1)) state_d = SEND_END;
        end
      end
      SEND_END: begin
        tx_data_c = END_BYTE;
        if (tx_ready) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load_now) begin
      shreg_d = load_data;
      seq_d   = SEQ_FIRST;
      idx_d   = '0;
      state_d = SEND_START;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      seq_q   <= SEQ_FIRST;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  // NOTE: the payload register is left unreset; it is always loaded before the state machine reads it.
  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
  end

  assign tx_valid = ~reset & (state_q != IDLE);
  assign tx_data  = reset ? START_BYTE : tx_data_c;
  assign done     = ~reset & done_q;

endmodule

// File: doc/frame_send.md
# frame_send

Transmit-side framer for the host UART link. Takes a 160-bit frame from the monitor logic and serializes it into the byte stream that the receive-side frame builder decodes. The stream is a start byte 0x00, then 40 nibble bytes {sequence[3:0], data[3:0]}, then an end byte 0x0F. The block sits between the frame source and the UART transmitter.

## Interface
- NIBBLES, 40, number of data nibbles per frame; frame width is 4*NIBBLES.
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- frame_valid  input  1  frame_data is valid.
- frame_ready  output  1  block accepts a frame; a transfer occurs on frame_valid & frame_ready at the clk edge.
- frame_data  input  160  frame payload; nibble [159:156] is sent first.
- tx_data  output  8  byte to the UART transmitter.
- tx_valid  output  1  tx_data is valid; held until accepted.
- tx_ready  input  1  UART transmitter accepts a byte; a byte transfer occurs on tx_valid & tx_ready.
- done  output  1  one-cycle pulse after the end byte transfers.

## Operation
- States:
  - IDLE: frame_ready=1; on accept, latch frame_data into the shift register, set seq=1 and idx=0, go to SEND_START.
  - SEND_START: tx_data=0x00; on transfer go to SEND_DATA.
  - SEND_DATA: tx_data={seq, shreg[159:156]}; on transfer shift shreg left by 4, advance seq (15 wraps to 1, never 0), idx+1; the transfer with idx==NIBBLES-1 goes to SEND_END.
  - SEND_END: tx_data=0x0F; on transfer pulse done and go to IDLE.
- seq is 1..15, so data bytes never equal 0x00 or 0x0F. Sequence for 40 nibbles: 1..15, 1..15, 1..10.
- tx_data and tx_valid do not change while tx_valid=1 and tx_ready=0.
- frame_ready=0 in all states other than IDLE, unless the queue option is enabled (see Configuration).
- Reset mid-frame:
  - Next edge: tx_valid=0, state=IDLE, frame discarded, no done pulse.
  - The receiver resynchronizes on the next 0x00.
- Reset values: tx_valid=0, tx_data=0x00, done=0, frame_ready=0 while reset is high.

## Timing
- Accept at edge N: tx_valid=1 with 0x00 from cycle N+1.
- With tx_ready held at 1:
  - 42 consecutive cycles of tx_valid;
  - done=1 in the cycle after the 0x0F transfer;
  - frame_ready=1 again in that same cycle.
- tx_ready low stalls the current byte indefinitely.
- frame_ready is a function of state and reset only; it does not depend on tx_ready or frame_valid.

## Configuration
- FRAME_SEND_QUEUE_EN defined:
  - Adds a one-deep holding register; frame_ready = ~hold_full, in any state.
  - A frame accepted during transmission is stored in the holding register.
  - On the 0x0F transfer with hold_full=1, load it, clear hold_full, pulse done, and go directly to SEND_START. The next 0x00 is presented in the following cycle.
  - Reset clears hold_full.
- Not defined: no holding register; frame_ready is high only in IDLE.

## Structure
- Shared package frame_uart_pkg holds:
  - START_BYTE=8'h00, END_BYTE=8'h0F;
  - FRAME_WIDTH=160, SEQ_FIRST=4'd1, SEQ_LAST=4'd15;
  - the state encoding IDLE/SEND_START/SEND_DATA/SEND_END.
- The receiver uses the same constants from this package.
- Sub-module frame_hold_buf (one-deep register with valid flag) is instantiated only under FRAME_SEND_QUEUE_EN.

## Test plan
- Frame 160'h0123456789ABCDEF0123456789ABCDEF01234567, tx_ready=1 -> bytes 00,10,21,32,…,FE,1F,20,…,A7,0F; 42 bytes; done one cycle after 0F.
- Same frame with tx_ready random 30% duty -> identical sequence; tx_data stable whenever tx_valid & ~tx_ready.
- All-zero frame -> data bytes 10,20,…,F0,10,…,F0,10,…,A0; no 00 or 0F between the start and end bytes.
- frame_valid pulsed during byte 5:
  - without QUEUE_EN -> ignored (frame_ready=0);
  - with QUEUE_EN -> accepted, and the second frame's 00 follows the first 0F in the next cycle.
- reset asserted after 10 data bytes -> tx_valid=0 next cycle, no done; next accepted frame starts with 00, seq=1.
- Loopback through UART tx/rx into the receive-side frame builder -> received frame equals sent frame over 100 random frames.
